// File: rtl/jk_pkg.sv
// Shared JK flip-flop encoding and load-value helper for the JK-based counters.
// jk[1] is J, jk[0] is K.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Saturate a load value into the legal count range 0..modulus-1.
  function automatic logic [31:0] clamp_mod(input logic [31:0] value, input logic [31:0] modulus);
    logic [31:0] res_s;
    if (value < modulus) begin
      res_s = value;
    end else begin
      res_s = modulus - 32'd1;
    end
    return res_s;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset.
// q and qbar are always exact complements.
module jk_cell
  import jk_pkg::*;
(
  input  logic [1:0] jk,
  input  logic       clk,
  input  logic       rst,
  output logic       q,
  output logic       qbar
);

  logic q_r;

  // JK state update; reset wins over the jk inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= 1'b0;
    end else begin
      case (jk)
        JK_HOLD:   q_r <= q_r;
        JK_RESET:  q_r <= 1'b0;
        JK_SET:    q_r <= 1'b1;
        JK_TOGGLE: q_r <= ~q_r;
        default:   q_r <= q_r;
      endcase
    end
  end

  assign q    = q_r;
  assign qbar = ~q_r;

endmodule

// File: rtl/jk_updown_counter.sv
// Mod-MOD synchronous up/down counter with clamped parallel load, stored in a bank of
// JK cells. tc flags the cycle whose edge wraps the count and is meant to enable a next stage.
module jk_updown_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MOD_M1 = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] qbar_s;
  logic [WIDTH-1:0] nxt_s;

  // Next count: load > count > hold; reset is applied inside the cells.
  // Out-of-range states (> MOD-1) wrap like the terminal value in either direction.
  always_comb begin
    nxt_s = q_s;
    if (load) begin
      nxt_s = WIDTH'(clamp_mod(32'(din), 32'(MOD)));
    end else if (en) begin
      if (up) begin
        if (q_s >= MOD_M1) begin
          nxt_s = ZERO;
        end else begin
          nxt_s = q_s + ONE;
        end
      end else begin
        if ((q_s == ZERO) || (q_s > MOD_M1)) begin
          nxt_s = MOD_M1;
        end else begin
          nxt_s = q_s - ONE;
        end
      end
    end else begin
      nxt_s = q_s;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic [1:0] jk_s;
    assign jk_s = {nxt_s[i], ~nxt_s[i]};
    jk_cell u_cell (
      .jk   (jk_s),
      .clk  (clk),
      .rst  (rst),
      .q    (q_s[i]),
      .qbar (qbar_s[i])
    );
  end

  assign q    = q_s;
  assign qbar = qbar_s;
  assign tc   = en & ((up & (q_s == MOD_M1)) | (~up & (q_s == ZERO)));

endmodule

// File: tb/tb_jk_updown_counter.sv
// Self-checking bench: decade counter, mod-16 counter and a two-stage decade cascade,
// all driven from the same inputs and compared against an arithmetic reference model.
module tb_jk_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] din;

  logic [3:0] q_a, qb_a, q_b, qb_b, q_c1, qb_c1, q_c2, qb_c2;
  logic       tc_a, tc_b, tc_c1, tc_c2;

  int checks = 0;
  int errors = 0;
  int ma, mb, mc1, mc2;
  bit mvalid = 1'b0;

  always #5 clk = ~clk;

  jk_updown_counter #(.WIDTH(4), .MOD(10)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q_a), .qbar(qb_a), .tc(tc_a));

  jk_updown_counter #(.WIDTH(4), .MOD(16)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q_b), .qbar(qb_b), .tc(tc_b));

  jk_updown_counter #(.WIDTH(4), .MOD(10)) dut_c1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q_c1), .qbar(qb_c1), .tc(tc_c1));

  jk_updown_counter #(.WIDTH(4), .MOD(10)) dut_c2 (
    .clk(clk), .rst(rst), .en(tc_c1), .up(up), .load(load), .din(din),
    .q(q_c2), .qbar(qb_c2), .tc(tc_c2));

  function automatic int model_next(int m, int modv, bit r, bit e, bit u, bit l, int d);
    if (r) return 0;
    if (l) return (d < modv) ? d : modv - 1;
    if (e) return u ? (m + 1) % modv : (m + modv - 1) % modv;
    return m;
  endfunction

  function automatic bit model_tc(int m, int modv, bit e, bit u);
    return e && (u ? (m == modv - 1) : (m == 0));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [3:0] qo, input logic [3:0] qbo, input int m);
    logic [3:0] e4;
    e4 = 4'(m);
    chk({tag, "_q"}, {28'd0, qo}, {28'd0, e4});
    chk({tag, "_qbar"}, {28'd0, qbo}, {28'd0, ~e4});
  endtask

  task automatic step(input bit r, input bit e, input bit u, input bit l, input int d);
    bit t1;
    rst = r; en = e; up = u; load = l; din = 4'(d);
    #1;
    t1 = model_tc(mc1, 10, e, u);
    if (mvalid) begin
      chk("tc_a",  {31'd0, tc_a},  {31'd0, model_tc(ma, 10, e, u)});
      chk("tc_b",  {31'd0, tc_b},  {31'd0, model_tc(mb, 16, e, u)});
      chk("tc_c1", {31'd0, tc_c1}, {31'd0, t1});
      chk("tc_c2", {31'd0, tc_c2}, {31'd0, model_tc(mc2, 10, t1, u)});
    end
    @(posedge clk);
    ma  = model_next(ma, 10, r, e, u, l, d);
    mb  = model_next(mb, 16, r, e, u, l, d);
    mc2 = model_next(mc2, 10, r, t1, u, l, d);
    mc1 = model_next(mc1, 10, r, e, u, l, d);
    if (r) mvalid = 1'b1;
    #1;
    if (mvalid) begin
      chk_q("a", q_a, qb_a, ma);
      chk_q("b", q_b, qb_b, mb);
      chk_q("c1", q_c1, qb_c1, mc1);
      chk_q("c2", q_c2, qb_c2, mc2);
    end
  endtask

  initial begin
    ma = 0; mb = 0; mc1 = 0; mc2 = 0;

    // reset held for two edges with en=1, up=1
    step(1'b1, 1'b1, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("rst_q", {28'd0, q_a}, 32'd0);
    chk("rst_qbar", {28'd0, qb_a}, 32'hF);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("rel3", {28'd0, q_a}, 32'd3);

    // up wrap from 8
    step(1'b0, 1'b0, 1'b1, 1'b1, 8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("upwrap", {28'd0, q_a}, 32'd1);

    // down wrap from 1
    step(1'b0, 1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("dnwrap", {28'd0, q_a}, 32'd8);

    // priority: load over en, hold on en=0, reset over load
    step(1'b0, 1'b0, 1'b1, 1'b1, 5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 2);
    chk("ld_over_en", {28'd0, q_a}, 32'd2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("hold", {28'd0, q_a}, 32'd2);
    step(1'b1, 1'b1, 1'b1, 1'b1, 7);
    chk("rst_over_ld", {28'd0, q_a}, 32'd0);

    // clamp, then full-range wrap on the mod-16 instance
    step(1'b0, 1'b0, 1'b1, 1'b1, 12);
    chk("clamp", {28'd0, q_a}, 32'd9);
    step(1'b0, 1'b0, 1'b1, 1'b1, 15);
    chk("m16_ld", {28'd0, q_b}, 32'd15);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("m16_up", {28'd0, q_b}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("m16_dn", {28'd0, q_b}, 32'd15);

    // cascade: 25 up edges from reset
    step(1'b1, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("cascade", {24'd0, q_c2, q_c1}, 32'h25);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
